// File: rtl/shared_dmem_pkg.sv
// Shared data-memory subsystem: common types and default sizing.
package shared_dmem_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   localparam int unsigned DEF_NUM_CORES  = 4;
   localparam int unsigned DEF_ADDR_W     = 16;
   localparam int unsigned DEF_DATA_W     = 16;
   localparam int unsigned DEF_DEPTH_LOG2 = 5;
   localparam int unsigned PERF_W         = 16;

   // Number of RAM words for a given index width.
   function automatic int unsigned ram_words(input int unsigned depth_log2);
      return 32'd1 << depth_log2;
   endfunction

endpackage

// File: rtl/shared_dmem_subsystem_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter
   import shared_dmem_pkg::*;
#(
   parameter  int unsigned NUM_CORES = DEF_NUM_CORES,
   localparam int unsigned PTR_W     = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [PTR_W-1:0]     ptr,
   output logic [NUM_CORES-1:0] gnt
);

   // Scan from ptr upward with wrap; the first active request wins.
   always_comb begin
      int unsigned idx;
      logic        found;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned off = 0; off < NUM_CORES; off++) begin
         idx = (32'(ptr) + off) % NUM_CORES;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_dmem_subsystem.sv
// N-port shared data memory: round-robin arbitration of core channels onto a
// single-port synchronous RAM, with bus lock for read-modify-write sequences.
// Optional per-core stall counters are enabled by defining SHARED_DMEM_PERF_EN.
module shared_dmem_subsystem
   import shared_dmem_pkg::*;
#(
   parameter  int unsigned NUM_CORES  = DEF_NUM_CORES,
   parameter  int unsigned ADDR_W     = DEF_ADDR_W,
   parameter  int unsigned DATA_W     = DEF_DATA_W,
   parameter  int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
   localparam int unsigned PTR_W      = $clog2(NUM_CORES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES-1:0]        we,
   input  logic [NUM_CORES-1:0]        lock,
   input  logic [NUM_CORES*ADDR_W-1:0] addr,
   input  logic [NUM_CORES*DATA_W-1:0] wdata,
   output logic [NUM_CORES-1:0]        gnt,
   output logic [NUM_CORES-1:0]        rvalid,
   output logic [DATA_W-1:0]           rdata
`ifdef SHARED_DMEM_PERF_EN
   ,
   input  logic [PTR_W-1:0]            perf_sel,
   output logic [PERF_W-1:0]           perf_stall
`endif
);

   localparam int unsigned WORDS = ram_words(DEPTH_LOG2);

   arb_state_e             state, state_nxt;
   logic [PTR_W-1:0]       ptr, ptr_nxt;
   logic [PTR_W-1:0]       owner, owner_nxt;
   logic [PTR_W-1:0]       g_idx;
   logic [NUM_CORES-1:0]   arb_req, arb_gnt;
   logic                   any_gnt;
   logic [ADDR_W-1:0]      addr_arr  [NUM_CORES];
   logic [DATA_W-1:0]      wdata_arr [NUM_CORES];
   logic [ADDR_W-1:0]      sel_addr;
   logic [DATA_W-1:0]      sel_wdata;
   logic                   sel_we;
   logic [DEPTH_LOG2-1:0]  word;
   logic                   unused_addr_hi;
   logic [DATA_W-1:0]      ram [WORDS];

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
      return (i == PTR_W'(NUM_CORES - 1)) ? '0 : i + 1'b1;
   endfunction

   // Unpack the per-core address and write-data buses.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
         wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
      end
   end

   // While locked only the owner's request reaches the arbiter.
   always_comb begin
      arb_req = (state == LOCKED) ? (req & (NUM_CORES'(1) << owner)) : req;
   end

   rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
      .req (arb_req),
      .ptr (ptr),
      .gnt (arb_gnt)
   );

   // Grant is suppressed in reset; encode the winner for the data muxes.
   always_comb begin
      gnt     = rst ? '0 : arb_gnt;
      any_gnt = |gnt;
      g_idx   = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (gnt[i]) g_idx = PTR_W'(i);
      end
      sel_addr       = addr_arr[g_idx];
      sel_wdata      = wdata_arr[g_idx];
      sel_we         = we[g_idx];
      word           = sel_addr[DEPTH_LOG2-1:0];
      unused_addr_hi = ^sel_addr[ADDR_W-1:DEPTH_LOG2];
   end

   // Next-state logic: enter lock on a locked grant, leave when the owner
   // drops lock or request; the pointer stays parked while locked.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      case (state)
         ARB: begin
            if (any_gnt) begin
               ptr_nxt = wrap_inc(g_idx);
               if (lock[g_idx]) begin
                  state_nxt = LOCKED;
                  owner_nxt = g_idx;
               end
            end
         end
         LOCKED: begin
            if (!req[owner] || !lock[owner]) begin
               state_nxt = ARB;
               ptr_nxt   = wrap_inc(owner);
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   // FSM, round-robin pointer and lock owner registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB;
         ptr   <= '0;
         owner <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
      end
   end

   // RAM write port (contents are not reset).
   always_ff @(posedge clk) begin
      if (any_gnt && sel_we) ram[word] <= sel_wdata;
   end

   // Read-return register: one-cycle latency, strobe routed to the requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= (any_gnt && !sel_we) ? gnt : '0;
         if (any_gnt && !sel_we) rdata <= ram[word];
      end
   end

`ifdef SHARED_DMEM_PERF_EN
   logic [PERF_W-1:0] stall_cnt [NUM_CORES];

   // Per-core saturating count of cycles spent requesting without a grant.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (rst) begin
            stall_cnt[i] <= '0;
         end else if (req[i] && !gnt[i] && (stall_cnt[i] != '1)) begin
            stall_cnt[i] <= stall_cnt[i] + 1'b1;
         end
      end
   end

   // Counter readout selected by perf_sel.
   always_comb begin
      perf_stall = stall_cnt[perf_sel];
   end
`endif

endmodule

// File: tb/tb_shared_dmem_subsystem.sv
// Directed bench for shared_dmem_subsystem with a read-return scoreboard.
module tb_shared_dmem_subsystem;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, we, lock;
   logic [63:0] addr, wdata;
   logic [3:0]  gnt, rvalid;
   logic [15:0] rdata;
   logic [15:0] a_v [4];
   logic [15:0] d_v [4];
   logic [15:0] mem [32];
`ifdef SHARED_DMEM_PERF_EN
   logic [1:0]  perf_sel = 2'd1;
   logic [15:0] perf_stall;
`endif

   typedef struct {
      int          due;
      logic [3:0]  onehot;
      logic [15:0] data;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         addr[i*16 +: 16]  = a_v[i];
         wdata[i*16 +: 16] = d_v[i];
      end
   end

   shared_dmem_subsystem #(
      .NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(5)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
      .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
`ifdef SHARED_DMEM_PERF_EN
      , .perf_sel(perf_sel), .perf_stall(perf_stall)
`endif
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic setc(input int i, input logic rq, input logic wr, input logic lk,
                       input logic [15:0] ad, input logic [15:0] dt);
      req[i]  = rq;
      we[i]   = wr;
      lock[i] = lk;
      a_v[i]  = ad;
      d_v[i]  = dt;
   endtask

   task automatic clr();
      for (int i = 0; i < 4; i++) setc(i, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   // Check the grant for this cycle, update the model from the expected
   // winner, queue any read return, then advance to just after the next edge.
   task automatic step(input logic [3:0] eg, input string nm);
      exp_t e;
      #3;
      check({nm, " gnt"}, 32'(gnt), 32'(eg));
      for (int i = 0; i < 4; i++) begin
         if (eg[i]) begin
            if (we[i]) begin
               mem[a_v[i][4:0]] = d_v[i];
            end else begin
               e.due    = cyc + 1;
               e.onehot = 4'(1 << i);
               e.data   = mem[a_v[i][4:0]];
               q.push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare each read return against the scoreboard when due.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         check("rvalid", 32'(rvalid), 32'(e.onehot));
         check("rdata", 32'(rdata), 32'(e.data));
      end else if (rvalid !== 4'b0000) begin
         check("unexpected rvalid", 32'(rvalid), 32'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clr();
      req = 4'hF;
      @(posedge clk);
      #1;

      // Reset held two cycles with requests present: no grants, outputs zero.
      for (int k = 0; k < 2; k++) begin
         #2;
         check("rst rvalid", 32'(rvalid), 32'h0);
         check("rst rdata", 32'(rdata), 32'h0);
         #(-0);
         step(4'b0000, "rst");
      end
      rst = 1'b0;
      clr();
      for (int k = 0; k < 2; k++) begin
         check("idle rvalid", 32'(rvalid), 32'h0);
         check("idle rdata", 32'(rdata), 32'h0);
         step(4'b0000, "idle");
      end

      // Write then read the same word from core 0.
      setc(0, 1, 1, 0, 16'h0003, 16'hBEEF); step(4'b0001, "t2 wr");
      setc(0, 1, 0, 0, 16'h0003, 16'h0000); step(4'b0001, "t2 rd");
      clr();                                  step(4'b0000, "t2 idle");

      // Preload words 0..2, then reset to park the pointer at 0.
      setc(1, 1, 1, 0, 16'h0001, 16'h1111); step(4'b0010, "pre w1");
      clr(); setc(2, 1, 1, 0, 16'h0002, 16'h2222); step(4'b0100, "pre w2");
      clr(); setc(3, 1, 1, 0, 16'h0000, 16'h0A0A); step(4'b1000, "pre w0");
      clr(); rst = 1'b1; step(4'b0000, "pre rst");
      rst = 1'b0;

      // All four cores reading continuously: rotation 0,1,2,3,0.
      for (int i = 0; i < 4; i++) setc(i, 1, 0, 0, 16'(i), 16'h0);
      step(4'b0001, "t3 g0");
      step(4'b0010, "t3 g1");
      step(4'b0100, "t3 g2");
      step(4'b1000, "t3 g3");
      step(4'b0001, "t3 g0b");
      clr(); step(4'b0000, "t3 idle");

      // Upper address bits ignored: 0x0023 and 0x0043 alias word 3.
      setc(1, 1, 0, 0, 16'h0023, 16'h0000); step(4'b0010, "t5 rd alias");
      clr(); setc(3, 1, 1, 0, 16'h0043, 16'h5A5A); step(4'b1000, "t5 wr alias");
      clr(); setc(0, 1, 0, 0, 16'h0003, 16'h0000); step(4'b0001, "t5 rd 3");
      clr(); rst = 1'b1; step(4'b0000, "t5 rst");
      rst = 1'b0;

      // Core 2 locks the bus for a read-modify-write; others stall.
      setc(2, 1, 0, 1, 16'h0002, 16'h0000); step(4'b0100, "t4 lock rd");
      setc(0, 1, 0, 0, 16'h0000, 16'h0000);
      setc(1, 1, 0, 0, 16'h0001, 16'h0000);
      setc(3, 1, 0, 0, 16'h0003, 16'h0000);
      step(4'b0100, "t4 lock rd2");
      setc(2, 1, 1, 1, 16'h0002, 16'h2223); step(4'b0100, "t4 lock wr");
      setc(2, 1, 0, 0, 16'h0002, 16'h0000); step(4'b0100, "t4 unlock rd");
      setc(2, 0, 0, 0, 16'h0000, 16'h0000); step(4'b1000, "t4 next c3");
      setc(3, 0, 0, 0, 16'h0000, 16'h0000); step(4'b0001, "t4 next c0");
      setc(0, 0, 0, 0, 16'h0000, 16'h0000);
`ifdef SHARED_DMEM_PERF_EN
      check("perf core1 stalls", 32'(perf_stall), 32'd5);
`endif
      step(4'b0010, "t4 next c1");
      clr(); step(4'b0000, "t4 idle");

      // Reset while core 1 holds the lock with a read in flight.
      setc(1, 1, 0, 1, 16'h0001, 16'h0000); step(4'b0010, "t6 lock rd");
      rst = 1'b1; step(4'b0000, "t6 rst");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) setc(i, 1, 0, 0, 16'(i), 16'h0);
      check("t6 rvalid dropped", 32'(rvalid), 32'h0);
`ifdef SHARED_DMEM_PERF_EN
      check("perf cleared", 32'(perf_stall), 32'd0);
`endif
      step(4'b0001, "t6 ptr0 unlocked");
      clr(); step(4'b0000, "end idle");
      step(4'b0000, "end idle2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
